// File: rtl/binary_rgb565_unpacker.sv
// Replays packed 1-bit pixel words as an RGB565 stream aligned to display timing.
// Two-word buffer (cur + nxt); lines restart on a fresh word, frames flush everything.
module binary_rgb565_unpacker #(
   parameter logic [15:0] FG_COLOR  = 16'hFFFF,
   parameter logic [15:0] BG_COLOR  = 16'h0000,
   parameter bit          BIT_ORDER = 1'b0
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        word_valid,
   input  logic [15:0] word_data,
   output logic        word_ready,
   input  logic        per_frame_vsync,
   input  logic        per_frame_href,
   input  logic        per_frame_clken,
   output logic        post_frame_vsync,
   output logic        post_frame_href,
   output logic        post_frame_clken,
   output logic        post_img_Bit,
   output logic [15:0] post_img_rgb565,
   output logic        underflow
);

   logic [15:0] cur_word;
   logic [15:0] nxt_word;
   logic        cur_valid;
   logic        nxt_valid;
   logic [3:0]  bit_idx;

   logic pix;
   logic vs_rise;
   logic line_end;
   logic acc;
   logic last;
   logic drop;
   logic vacate;
   logic cur_bit;
   logic pix_bit;

   assign pix      = per_frame_href & per_frame_clken;
   assign vs_rise  = per_frame_vsync & ~post_frame_vsync;
   assign line_end = post_frame_href & ~per_frame_href;

   assign word_ready = ~nxt_valid & ~vs_rise;
   assign acc        = word_valid & word_ready;

   assign last   = pix & cur_valid & (bit_idx == 4'd15);
   assign drop   = line_end & (bit_idx != 4'd0);
   assign vacate = last | drop;

   assign cur_bit = BIT_ORDER ? cur_word[bit_idx]
                              : cur_word[4'd15 - bit_idx];
   assign pix_bit = cur_valid & cur_bit;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         post_frame_vsync <= 1'b0;
         post_frame_href  <= 1'b0;
         post_frame_clken <= 1'b0;
         post_img_Bit     <= 1'b0;
         post_img_rgb565  <= BG_COLOR;
         underflow        <= 1'b0;
         cur_word         <= 16'h0000;
         nxt_word         <= 16'h0000;
         cur_valid        <= 1'b0;
         nxt_valid        <= 1'b0;
         bit_idx          <= 4'd0;
      end else begin
         post_frame_vsync <= per_frame_vsync;
         post_frame_href  <= per_frame_href;
         post_frame_clken <= per_frame_clken;

         if (pix) begin
            post_img_Bit    <= pix_bit;
            post_img_rgb565 <= pix_bit ? FG_COLOR : BG_COLOR;
         end

         if (vs_rise) begin
            cur_valid <= 1'b0;
            nxt_valid <= 1'b0;
            bit_idx   <= 4'd0;
            underflow <= 1'b0;
         end else begin
            if (pix & ~cur_valid)
               underflow <= 1'b1;
            if (vacate) begin
               // acc implies nxt is empty, so at most one source refills cur
               bit_idx <= 4'd0;
               if (nxt_valid) begin
                  cur_word  <= nxt_word;
                  cur_valid <= 1'b1;
                  nxt_valid <= 1'b0;
               end else if (acc) begin
                  cur_word  <= word_data;
                  cur_valid <= 1'b1;
               end else begin
                  cur_valid <= 1'b0;
               end
            end else begin
               if (pix & cur_valid)
                  bit_idx <= bit_idx + 4'd1;
               if (acc) begin
                  if (!cur_valid) begin
                     cur_word  <= word_data;
                     cur_valid <= 1'b1;
                  end else begin
                     nxt_word  <= word_data;
                     nxt_valid <= 1'b1;
                  end
               end
            end
         end
      end
   end

endmodule

// File: tb/tb_binary_rgb565_unpacker.sv
// Randomized and directed bench for binary_rgb565_unpacker.
// Reference model: a queue of accepted words plus a bit position.
module tb_binary_rgb565_unpacker;

   logic        clk = 1'b0;
   logic        rst;
   logic        word_valid;
   logic [15:0] word_data;
   logic        word_ready;
   logic        per_frame_vsync;
   logic        per_frame_href;
   logic        per_frame_clken;
   logic        post_frame_vsync;
   logic        post_frame_href;
   logic        post_frame_clken;
   logic        post_img_Bit;
   logic [15:0] post_img_rgb565;
   logic        underflow;

   binary_rgb565_unpacker dut (
      .clk              (clk),
      .rst              (rst),
      .word_valid       (word_valid),
      .word_data        (word_data),
      .word_ready       (word_ready),
      .per_frame_vsync  (per_frame_vsync),
      .per_frame_href   (per_frame_href),
      .per_frame_clken  (per_frame_clken),
      .post_frame_vsync (post_frame_vsync),
      .post_frame_href  (post_frame_href),
      .post_frame_clken (post_frame_clken),
      .post_img_Bit     (post_img_Bit),
      .post_img_rgb565  (post_img_rgb565),
      .underflow        (underflow)
   );

   always #5 clk = ~clk;

   int n_cmp = 0;
   int n_err = 0;

   task automatic check(input string tag, input logic [31:0] got,
                        input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
      end
   endtask

   logic [15:0] q[$];
   int          pos;
   logic        m_uf, m_bit, m_vs, m_hr, m_ck;

   task automatic model_clear();
      q.delete();
      pos = 0;
      m_uf = 0; m_bit = 0; m_vs = 0; m_hr = 0; m_ck = 0;
   endtask

   task automatic step(input logic vs, input logic hr, input logic ck,
                       input logic wv, input logic [15:0] wd);
      logic rise, le, p, rdy, acc;
      logic [15:0] w;
      @(negedge clk);
      per_frame_vsync = vs;
      per_frame_href  = hr;
      per_frame_clken = ck;
      word_valid      = wv;
      word_data       = wd;
      rise = vs & ~m_vs;
      le   = m_hr & ~hr;
      p    = hr & ck;
      rdy  = (q.size() < 2) && !rise;
      #1 check("ready", word_ready, rdy);
      acc = wv & rdy;
      if (p) begin
         if (q.size() == 0) begin
            m_bit = 1'b0;
            m_uf  = 1'b1;
         end else begin
            w = q[0];
            m_bit = w[15 - pos];
            pos++;
            if (pos == 16) begin
               void'(q.pop_front());
               pos = 0;
            end
         end
      end
      if (le && pos != 0) begin
         void'(q.pop_front());
         pos = 0;
      end
      if (acc) q.push_back(wd);
      if (rise) begin
         q.delete();
         pos = 0;
         m_uf = 1'b0;
      end
      m_vs = vs; m_hr = hr; m_ck = ck;
      @(posedge clk);
      #1;
      check("vsync", post_frame_vsync, m_vs);
      check("href", post_frame_href, m_hr);
      check("clken", post_frame_clken, m_ck);
      check("bit", post_img_Bit, m_bit);
      check("rgb", post_img_rgb565, m_bit ? 16'hFFFF : 16'h0000);
      check("underflow", underflow, m_uf);
   endtask

   task automatic idle();
      step(0, 0, 0, 0, 16'h0);
   endtask

   initial begin
      #2ms;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "timeout");
   end

   initial begin
      logic [15:0] pat;
      rst = 1'b1;
      word_valid = 0; word_data = 0;
      per_frame_vsync = 0; per_frame_href = 0; per_frame_clken = 0;
      model_clear();
      repeat (3) @(posedge clk);
      #1;
      check("rst_vs", post_frame_vsync, 0);
      check("rst_bit", post_img_Bit, 0);
      check("rst_rgb", post_img_rgb565, 16'h0000);
      check("rst_uf", underflow, 0);
      @(negedge clk);
      rst = 1'b0;
      #1 check("rst_ready", word_ready, 1);

      // Directed: A5F0 MSB first
      step(1, 0, 0, 0, 16'h0);
      idle();
      step(0, 0, 0, 1, 16'hA5F0);
      pat = 16'hA5F0;
      for (int i = 0; i < 16; i++) begin
         step(0, 1, 1, 0, 16'h0);
         check("a5f0_bit", post_img_Bit, pat[15 - i]);
      end
      idle();

      // Back-to-back FFFF then 0000 with continuous strobe
      step(0, 0, 0, 1, 16'hFFFF);
      step(0, 0, 0, 1, 16'h0000);
      for (int i = 0; i < 32; i++) begin
         step(0, 1, 1, 0, 16'h0);
         check("b2b_bit", post_img_Bit, (i < 16) ? 1 : 0);
      end
      idle();

      // 20-pixel line, partial word dropped at line end
      step(0, 0, 0, 1, 16'hFFFF);
      step(0, 0, 0, 1, 16'hF000);
      for (int i = 0; i < 20; i++) begin
         step(0, 1, 1, (i == 17), 16'h0F0F);
         check("line1_bit", post_img_Bit, 1);
      end
      idle();
      pat = 16'h0F0F;
      for (int i = 0; i < 16; i++) begin
         step(0, 1, 1, 0, 16'h0);
         check("line2_bit", post_img_Bit, pat[15 - i]);
      end
      idle();

      // Underflow: sticky, cleared by vsync rise
      for (int i = 0; i < 3; i++) step(0, 1, 1, 0, 16'h0);
      check("uf_set", underflow, 1);
      idle();
      idle();
      check("uf_hold", underflow, 1);
      step(1, 0, 0, 0, 16'h0);
      check("uf_clear", underflow, 0);
      step(0, 0, 0, 0, 16'h0);

      // Flush with nxt full and a word offered in the same cycle
      step(0, 0, 0, 1, 16'h1234);
      step(0, 0, 0, 1, 16'h5678);
      step(1, 0, 0, 1, 16'h9ABC);
      step(0, 1, 1, 0, 16'h0);
      check("flush_uf", underflow, 1);
      idle();

      // Randomized frames
      for (int f = 0; f < 6; f++) begin
         step(1, 0, 0, $urandom_range(0, 1), 16'($urandom));
         step(1, 0, 0, $urandom_range(0, 1), 16'($urandom));
         for (int l = 0; l < 8; l++) begin
            int len;
            len = $urandom_range(5, 40);
            for (int c = 0; c < len; c++)
               step(0, 1, ($urandom_range(0, 3) != 0),
                    ($urandom_range(0, 9) < 7), 16'($urandom));
            for (int g = 0; g < 3; g++)
               step(0, 0, 0, $urandom_range(0, 1), 16'($urandom));
         end
         if (f == 3) begin
            // Mid-stream reset discards buffered words
            step(0, 1, 1, 1, 16'hBEEF);
            @(negedge clk);
            rst = 1'b1;
            word_valid = 0;
            per_frame_vsync = 0; per_frame_href = 0; per_frame_clken = 0;
            #1;
            check("mrst_href", post_frame_href, 0);
            check("mrst_rgb", post_img_rgb565, 16'h0000);
            @(negedge clk);
            rst = 1'b0;
            model_clear();
            #1 check("mrst_ready", word_ready, 1);
         end
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
